uart_tx: RTL

Serial UART transmitter: the transmit half of the UART block, paired with the existing receiver and driven by the same baud-rate generator tick. It accepts a parallel byte on a single-cycle request and shifts it out as an asynchronous frame: start bit, 5–8 data bits LSB first, no parity, 1 or 2 stop bits. It signals completion with a one-cycle done pulse, so an opcode-driven controller can issue back-to-back frames.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, no parity,
// STOP_BITS stop bits. Bit timing comes from the shared baud tick, with
// OVERSAMPLE ticks per bit. A one-cycle tx_done pulse marks frame end so
// a new frame can be requested in that same cycle without an idle gap.
module uart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    input  logic [3:0] n_bits,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt, tick_cnt_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [3:0]    nbits_eff, nbits_eff_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next, busy_next, done_next;
    logic          bit_end;

    // The current bit period closes on the edge that sees its last tick.
    assign bit_end = tick && (tick_cnt == TICK_LAST);

    // State and datapath registers; outputs are registered so tx has no
    // combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            nbits_eff <= 4'd8;
            shift     <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            bit_cnt   <= bit_cnt_next;
            nbits_eff <= nbits_eff_next;
            shift     <= shift_next;
            tx        <= tx_next;
            busy      <= busy_next;
            tx_done   <= done_next;
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_next     = state;
        tick_cnt_next  = tick_cnt;
        bit_cnt_next   = bit_cnt;
        nbits_eff_next = nbits_eff;
        shift_next     = shift;
        done_next      = 1'b0;

        // Ticks only count while a frame is in flight; a tick coincident
        // with acceptance is dropped because IDLE forces the count to 0.
        if (state != IDLE && tick) begin
            tick_cnt_next = bit_end ? '0 : tick_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tick_cnt_next = '0;
                bit_cnt_next  = '0;
                if (tx_en) begin
                    shift_next     = tx_data;
                    nbits_eff_next = (n_bits >= 4'd5 && n_bits <= 4'd8) ? n_bits : 4'd8;
                    state_next     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_cnt + 4'd1 >= nbits_eff) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                // bit_cnt is reused to count stop-bit periods.
                if (bit_end) begin
                    if (bit_cnt >= STOP_LAST) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered line
    // changes on the same edge as the state.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule
